// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//   Forwarding and hazard controller for the in-order pipeline. It sits beside
//   the ID/EX registers, selects the EX operand forwarding source for each of
//   NUM_SRC operands from NUM_STAGES downstream producers, stalls on EX data
//   that is not yet available, sequences load-use stalls of LOAD_LAT cycles,
//   and freezes the whole pipe while the data memory is busy.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   id_*             ID instruction: valid, source registers, source-used mask
//   ex_*             EX instruction: valid, rd, reg write, is-load, sources
//   stg_*            per producer stage (0 = EX/MEM ... oldest = WB):
//                    rd, reg write, result available
//   mem_busy         data memory not ready, freeze everything
//   fwd_sel          per EX source: 0 = register file, i+1 = stage i
//   stall_if/id/ex   hold PC, IF/ID, ID/EX
//   bubble_ex/mem    load NOP into ID/EX, EX/MEM
//   fsm_state        0 RUN, 1 LU_STALL, 2 MEM_WAIT
//
// Optional build macro HAZ_PERF_CNT_EN adds saturating counters
//   lu_stall_cnt (load-use bubble cycles) and mem_stall_cnt (mem_busy cycles).
module fwd_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int ZERO_REG   = 1,
  localparam int SELW      = $clog2(NUM_STAGES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]          id_rs_used,
  input  logic                        ex_valid,
  input  logic [REG_AW-1:0]           ex_rd,
  input  logic                        ex_reg_wr,
  input  logic                        ex_is_load,
  input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
  input  logic [NUM_STAGES*REG_AW-1:0] stg_rd,
  input  logic [NUM_STAGES-1:0]       stg_reg_wr,
  input  logic [NUM_STAGES-1:0]       stg_data_ok,
  input  logic                        mem_busy,
  output logic [NUM_SRC*SELW-1:0]     fwd_sel,
  output logic                        stall_if,
  output logic                        stall_id,
  output logic                        stall_ex,
  output logic                        bubble_ex,
  output logic                        bubble_mem,
  output logic [1:0]                  fsm_state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]                 lu_stall_cnt,
  output logic [31:0]                 mem_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d, ret_q, ret_d, eff;
  logic [7:0] cnt_q, cnt_d;

  logic [NUM_SRC*SELW-1:0] fwd_sel_c;
  logic ex_haz, found, win_ok;
  logic lu, rd_ok, src_hit, lu_stall;

  // Forward select: scan from the youngest stage, first match wins.
  always_comb begin
    fwd_sel_c = '0;
    ex_haz    = 1'b0;
    found     = 1'b0;
    win_ok    = 1'b1;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      found  = 1'b0;
      win_ok = 1'b1;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        if (!found && stg_reg_wr[i] &&
            stg_rd[i*REG_AW +: REG_AW] == ex_rs[k*REG_AW +: REG_AW] &&
            !(ZERO_REG != 0 && stg_rd[i*REG_AW +: REG_AW] == '0)) begin
          found  = 1'b1;
          win_ok = stg_data_ok[i];
          fwd_sel_c[k*SELW +: SELW] = SELW'(i + 1);
        end
      end
      if (found && !win_ok) ex_haz = 1'b1;
    end
  end

  // Load in EX whose rd is read by the instruction in ID.
  always_comb begin
    rd_ok   = !(ZERO_REG != 0 && ex_rd == '0);
    src_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (id_rs_used[k] && id_rs[k*REG_AW +: REG_AW] == ex_rd) src_hit = 1'b1;
    end
    lu = ex_valid && ex_is_load && ex_reg_wr && rd_ok && id_valid && src_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  // The cycle mem_busy drops out of MEM_WAIT behaves exactly like the saved
  // return state, so a frozen load-use stall loses none of its bubbles.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    cnt_d    = cnt_q;
    lu_stall = 1'b0;
    eff      = (state_q == MEM_WAIT) ? ret_q : state_q;
    if (mem_busy) begin
      state_d = MEM_WAIT;
      ret_d   = eff;
    end else begin
      state_d = eff;
      case (eff)
        RUN: begin
          if (lu) begin
            lu_stall = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LU_STALL;
              cnt_d   = 8'(LOAD_LAT - 1);
            end
          end
        end
        LU_STALL: begin
          lu_stall = 1'b1;
          cnt_d    = cnt_q - 8'd1;
          state_d  = (cnt_q == 8'd1) ? RUN : LU_STALL;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign fwd_sel    = rst ? '0 : fwd_sel_c;
  assign stall_if   = !rst && (mem_busy || lu_stall || ex_haz);
  assign stall_id   = !rst && (mem_busy || lu_stall || ex_haz);
  assign stall_ex   = !rst && (mem_busy || ex_haz);
  assign bubble_ex  = !rst && !mem_busy && lu_stall;
  assign bubble_mem = !rst && !mem_busy && ex_haz;
  assign fsm_state  = state_q;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_stall_cnt  <= '0;
      mem_stall_cnt <= '0;
    end else begin
      if (bubble_ex && lu_stall_cnt != '1) lu_stall_cnt <= lu_stall_cnt + 32'd1;
      if (mem_busy && mem_stall_cnt != '1) mem_stall_cnt <= mem_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;
  localparam int AW   = 5;
  localparam int NSRC = 2;
  localparam int NSTG = 2;
  localparam int LL   = 3;
  localparam int SW   = 2;

  logic clk = 1'b0;
  logic rst;
  logic id_valid;
  logic [NSRC*AW-1:0] id_rs;
  logic [NSRC-1:0] id_rs_used;
  logic ex_valid;
  logic [AW-1:0] ex_rd;
  logic ex_reg_wr;
  logic ex_is_load;
  logic [NSRC*AW-1:0] ex_rs;
  logic [NSTG*AW-1:0] stg_rd;
  logic [NSTG-1:0] stg_reg_wr;
  logic [NSTG-1:0] stg_data_ok;
  logic mem_busy;
  logic [NSRC*SW-1:0] fwd_sel;
  logic stall_if, stall_id, stall_ex, bubble_ex, bubble_mem;
  logic [1:0] fsm_state;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] lu_stall_cnt, mem_stall_cnt;
`endif

  fwd_hazard_ctrl #(
    .REG_AW(AW), .NUM_SRC(NSRC), .NUM_STAGES(NSTG), .LOAD_LAT(LL), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
    .ex_is_load(ex_is_load), .ex_rs(ex_rs),
    .stg_rd(stg_rd), .stg_reg_wr(stg_reg_wr), .stg_data_ok(stg_data_ok),
    .mem_busy(mem_busy),
    .fwd_sel(fwd_sel), .stall_if(stall_if), .stall_id(stall_id),
    .stall_ex(stall_ex), .bubble_ex(bubble_ex), .bubble_mem(bubble_mem),
    .fsm_state(fsm_state)
`ifdef HAZ_PERF_CNT_EN
    , .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  // Reference model: stall cycles still owed, and whether the pipe is frozen.
  int pend    = 0;
  bit waiting = 1'b0;
  logic [31:0] m_lu_cnt  = '0;
  logic [31:0] m_mem_cnt = '0;

  logic       o_bex;
  logic [1:0] o_state;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest matching producer: scan oldest to youngest, last hit wins.
  function automatic int ref_sel(input int k);
    logic [AW-1:0] rs, rd;
    int sel;
    rs  = ex_rs[k*AW +: AW];
    sel = 0;
    for (int i = NSTG - 1; i >= 0; i--) begin
      rd = stg_rd[i*AW +: AW];
      if (stg_reg_wr[i] && rd == rs && rd != '0) sel = i + 1;
    end
    return sel;
  endfunction

  function automatic bit ref_lu();
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < NSRC; k++)
      if (id_rs_used[k] && id_rs[k*AW +: AW] == ex_rd) hit = 1'b1;
    return ex_valid && ex_is_load && ex_reg_wr && ex_rd != '0 && id_valid && hit;
  endfunction

  task automatic cycle(input string tag);
    logic [NSRC*SW-1:0] e_fwd;
    logic [1:0] e_st;
    logic e_sif, e_sex, e_bex, e_bmem;
    bit haz, lub;
    int s;
    #1;
    e_st  = rst ? 2'd0 : waiting ? 2'd2 : (pend > 0 ? 2'd1 : 2'd0);
    e_fwd = '0;
    haz   = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      s = ref_sel(k);
      e_fwd[k*SW +: SW] = SW'(s);
      if (s != 0 && !stg_data_ok[s-1]) haz = 1'b1;
    end
    if (rst) begin
      e_fwd = '0; e_sif = 1'b0; e_sex = 1'b0; e_bex = 1'b0; e_bmem = 1'b0;
      pend = 0; waiting = 1'b0; m_lu_cnt = '0; m_mem_cnt = '0;
    end else if (mem_busy) begin
      e_sif = 1'b1; e_sex = 1'b1; e_bex = 1'b0; e_bmem = 1'b0;
    end else begin
      lub    = (pend > 0) || ref_lu();
      e_sif  = lub || haz;
      e_sex  = haz;
      e_bex  = lub;
      e_bmem = haz;
    end
    chk({tag, ".fwd_sel"},    64'(fwd_sel),    64'(e_fwd));
    chk({tag, ".stall_if"},   64'(stall_if),   64'(e_sif));
    chk({tag, ".stall_id"},   64'(stall_id),   64'(e_sif));
    chk({tag, ".stall_ex"},   64'(stall_ex),   64'(e_sex));
    chk({tag, ".bubble_ex"},  64'(bubble_ex),  64'(e_bex));
    chk({tag, ".bubble_mem"}, 64'(bubble_mem), 64'(e_bmem));
    chk({tag, ".fsm_state"},  64'(fsm_state),  64'(e_st));
`ifdef HAZ_PERF_CNT_EN
    chk({tag, ".lu_stall_cnt"},  64'(lu_stall_cnt),  64'(m_lu_cnt));
    chk({tag, ".mem_stall_cnt"}, 64'(mem_stall_cnt), 64'(m_mem_cnt));
`endif
    if (!rst) begin
      if (e_bex && m_lu_cnt != '1) m_lu_cnt++;
      if (mem_busy && m_mem_cnt != '1) m_mem_cnt++;
      if (mem_busy) waiting = 1'b1;
      else begin
        waiting = 1'b0;
        if (pend > 0) pend--;
        else if (ref_lu()) pend = LL - 1;
      end
    end
    o_bex   = bubble_ex;
    o_state = fsm_state;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs = '0; id_rs_used = '0;
    ex_valid = 1'b0; ex_rd = '0; ex_reg_wr = 1'b0; ex_is_load = 1'b0; ex_rs = '0;
    stg_rd = '0; stg_reg_wr = '0; stg_data_ok = '0; mem_busy = 1'b0;
  endtask

  task automatic load_x7(input logic [NSRC-1:0] used);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd7;
    id_valid = 1'b1; id_rs = {5'd3, 5'd7}; id_rs_used = used;
  endtask

  logic [1:0] st_seq [8];
  int nb, nw;

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk); cycle("reset");
    chk("reset_state", 64'(fsm_state), 64'd0);
    @(negedge clk); rst = 1'b0; cycle("idle");

    // Forwarding priority and register 0.
    @(negedge clk);
    ex_rs = {5'd0, 5'd5}; stg_rd = {5'd5, 5'd5}; stg_reg_wr = 2'b11; stg_data_ok = 2'b11;
    cycle("fwd_both");
    chk("fwd_youngest", 64'(fwd_sel[1:0]), 64'd1);
    @(negedge clk); stg_rd = {5'd5, 5'd3}; cycle("fwd_old");
    chk("fwd_stage1", 64'(fwd_sel[1:0]), 64'd2);
    @(negedge clk); ex_rs = '0; stg_rd = '0; cycle("fwd_x0");
    chk("fwd_zero_reg", 64'(fwd_sel), 64'd0);

    // Load-use, LOAD_LAT=3.
    @(negedge clk); idle(); cycle("idle");
    nb = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) load_x7(2'b01); else ex_valid = 1'b0;
      cycle("lu");
      st_seq[c] = o_state; nb += int'(o_bex);
    end
    chk("lu_bubbles", 64'(nb), 64'd3);
    chk("lu_st0", 64'(st_seq[0]), 64'd0);
    chk("lu_st1", 64'(st_seq[1]), 64'd1);
    chk("lu_st2", 64'(st_seq[2]), 64'd1);
    chk("lu_st3", 64'(st_seq[3]), 64'd0);

    // Source not used: no stall.
    @(negedge clk); idle(); load_x7(2'b00); cycle("lu_unused");
    chk("lu_unused_bubble", 64'(bubble_ex), 64'd0);
    @(negedge clk); idle(); cycle("idle");

    // Load-use frozen by mem_busy for 4 cycles from the second stall cycle.
    nb = 0; nw = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) load_x7(2'b01); else ex_valid = 1'b0;
      mem_busy = (c >= 1 && c <= 4);
      cycle("lu_mem");
      st_seq[c % 8] = o_state; nb += int'(o_bex); nw += int'(o_state == 2'd2);
    end
    chk("lu_mem_bubbles", 64'(nb), 64'd3);
    chk("lu_mem_waits", 64'(nw), 64'd4);
    chk("lu_mem_st6", 64'(st_seq[6]), 64'd1);
    chk("lu_mem_st7", 64'(st_seq[7]), 64'd0);

    // EX data hazard then data ready.
    @(negedge clk); idle();
    ex_rs = {5'd9, 5'd0}; stg_rd = {5'd0, 5'd9}; stg_reg_wr = 2'b01; stg_data_ok = 2'b00;
    cycle("exhaz");
    chk("exhaz_stall_ex", 64'(stall_ex), 64'd1);
    chk("exhaz_bubble_mem", 64'(bubble_mem), 64'd1);
    @(negedge clk); stg_data_ok = 2'b01; cycle("exhaz_ok");
    chk("exhaz_ok_stall_ex", 64'(stall_ex), 64'd0);
    chk("exhaz_ok_fwd_src1", 64'(fwd_sel[3:2]), 64'd1);

    // Reset in the middle of a load-use stall.
    @(negedge clk); idle(); load_x7(2'b01); cycle("lu_rst0");
    @(negedge clk); ex_valid = 1'b0; cycle("lu_rst1");
    chk("lu_rst_in_stall", 64'(fsm_state), 64'd1);
    @(negedge clk); rst = 1'b1; cycle("rst_mid");
    chk("rst_mid_state", 64'(fsm_state), 64'd0);
    chk("rst_mid_stall", 64'({stall_if, stall_id, stall_ex, bubble_ex, bubble_mem}), 64'd0);
    @(negedge clk); rst = 1'b0; idle(); cycle("after_rst");

    // Randomized traffic with small register numbers to force matches.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 99) == 0);
      id_valid    = 1'($urandom);
      id_rs       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_rs_used  = 2'($urandom);
      ex_valid    = 1'($urandom);
      ex_rd       = 5'($urandom_range(0, 3));
      ex_reg_wr   = 1'($urandom);
      ex_is_load  = ($urandom_range(0, 2) == 0);
      ex_rs       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      stg_rd      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      stg_reg_wr  = 2'($urandom);
      stg_data_ok = 2'($urandom) | 2'($urandom);
      mem_busy    = ($urandom_range(0, 5) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
